// File: rtl/alu_nbit_seq.sv
// Registered W-bit ALU with valid/ready handshakes and an iterative shift-add multiply.
// Define ALU_FLAGS_EN to add the {V,C,N,Z} flags port and its flag registers.

module alu_nbit_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]   flags
`endif
);

    // state | meaning
    // IDLE  | no operation held; ready for a new one
    // BUSY  | multiply iterating, one multiplier bit per cycle
    // DONE  | result register valid, waiting for the consumer

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    // Without flags only the low W product bits matter, so the multiply path shrinks to W.
`ifdef ALU_FLAGS_EN
    localparam int PW = 2 * W;
`else
    localparam int PW = W;
`endif
    localparam int CW = $clog2(W) + 1;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    result_q, result_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic            mul_last;
    logic [PW-1:0]   mul_step;
    logic [PW-1:0]   acc_first;
    logic [W-1:0]    add_res;
    logic [W-1:0]    sub_res;
    logic [W-1:0]    alu_res;

    assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign result    = result_q;

`ifdef ALU_FLAGS_EN
    localparam logic [W:0] ONE_EXT = {{W{1'b0}}, 1'b1};
    logic [W:0] add_ext;
    logic [W:0] sub_ext;

    assign add_ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sub_ext = {1'b0, a} + {1'b0, ~b} + ONE_EXT;
    assign add_res = add_ext[W-1:0];
    assign sub_res = sub_ext[W-1:0];
`else
    assign add_res = a + b + {{(W-1){1'b0}}, cin};
    assign sub_res = a - b;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            OP_NAND: alu_res = ~(a & b);
            OP_NOR:  alu_res = ~(a | b);
            OP_ADD:  alu_res = add_res;
            OP_SUB:  alu_res = sub_res;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // The accept edge already consumes b[0]; BUSY then covers the remaining W-1 bits.
    assign acc_first = b[0] ? PW'(a) : '0;
    assign mul_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (state_q == ST_BUSY) && (cnt_q == CW'(1));

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        if (accept) begin
            if (op == OP_MUL) begin
                state_d  = ST_BUSY;
                valid_d  = 1'b0;
                acc_d    = acc_first;
                mcand_d  = PW'(a) << 1;
                mplier_d = b >> 1;
                cnt_d    = CW'(W - 1);
            end else begin
                state_d  = ST_DONE;
                valid_d  = 1'b1;
                result_d = alu_res;
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    acc_d    = mul_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                    if (mul_last) begin
                        state_d  = ST_DONE;
                        valid_d  = 1'b1;
                        result_d = mul_step[W-1:0];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       alu_c;
    logic       alu_v;

    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (op)
            OP_ADD: begin
                alu_c = add_ext[W];
                alu_v = (a[W-1] == b[W-1]) && (add_ext[W-1] != a[W-1]);
            end
            OP_SUB: begin
                alu_c = sub_ext[W];
                alu_v = (a[W-1] != b[W-1]) && (sub_ext[W-1] != a[W-1]);
            end
            default: ;
        endcase
    end

    // Flags follow the result register: loaded only when result_q is loaded.
    always_comb begin
        flags_d = flags_q;
        if (accept && (op != OP_MUL)) begin
            flags_d = {alu_v, alu_c, alu_res[W-1], (alu_res == '0)};
        end else if (!accept && mul_last) begin
            flags_d = {1'b0, |mul_step[PW-1:W], mul_step[W-1], (mul_step[W-1:0] == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: doc/alu_nbit_seq.md
Name: alu_nbit_seq

Overview:
- Parametrised, registered successor to the team's 2/4-bit ripple ALU slices.
- Extends the original op set (NAND, NOR, ADD, SUB) with AND, OR, XOR and an iterative shift-add multiply.
- Wraps everything in valid/ready handshakes on input and output, with a single result register.
- Sits between operand-fetch logic and a result consumer; one operation in flight at a time.

Parameters:
- W, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in, used by ADD only.
- op  input  3  operation select.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  W  registered result.
- flags  output  4  {V,C,N,Z}; present only with ALU_FLAGS_EN.

Behaviour:
- Op encoding:
  - 000 NAND, 001 NOR, 010 ADD (a+b+cin), 011 SUB (a+~b+1; cin ignored).
  - 100 AND, 101 OR, 110 XOR.
  - 111 MUL (low W bits of a*b, unsigned).
- States: IDLE, BUSY (MUL in progress), DONE (result held).
- Reset:
  - state=IDLE, out_valid=0, result=0, flags=0, multiply counter/partials cleared.
  - in_ready=0 while rst is high.
  - rst overrides everything, including mid-MUL; the partial product is discarded and no out_valid is produced for it.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Combinational; no dependency on in_valid.
- Accept = in_valid && in_ready. Operands and op are captured only on accept.
- Single-cycle ops (000–110): accepted at edge t, result/flags registered at the same edge; out_valid=1 from cycle t+1. State goes to DONE.
- MUL: accepted at edge t → BUSY.
  - One shift-add iteration per cycle, LSB of b first.
  - After W iterations: result loaded, state=DONE, out_valid=1 in cycle t+W.
  - in_ready=0 throughout BUSY.
- Output handshake:
  - DONE with out_ready=1 and no new accept → IDLE, out_valid=0.
  - DONE with out_ready=1 and a new accept → back-to-back; the next op is loaded the same edge. Single-cycle op keeps out_valid=1; MUL goes to BUSY with out_valid=0.
  - DONE with out_ready=0: result/flags held stable, in_ready=0.
- Flags:
  - Z = (result==0) for all ops; N = result[W-1] for all ops.
  - C: carry-out of bit W-1 for ADD; no-borrow carry for SUB; for MUL, C=1 iff high W bits of the 2W-bit product are nonzero; 0 for logic ops.
  - V: signed overflow for ADD/SUB (operands same effective sign, result sign differs); 0 otherwise.
- Inputs are don't-care when no accept occurs. out_ready is ignored when out_valid=0.

Optional Feature:
- ALU_FLAGS_EN defined:
  - The flags port exists.
  - Flag registers are computed and held with result per the rules above.
  - Flags reset to 0.
- Not defined:
  - The flags port and all flag logic are omitted.
  - Result, latency and handshake timing are identical.

Test Plan:
- W=4, reset: hold rst 2 cycles, then release → out_valid=0, result=0000, in_ready=0 during rst and 1 in the first cycle after.
- W=4, ADD a=0111 b=1001 cin=0, out_ready=1 → next cycle result=0000, flags V=0 C=1 N=0 Z=1. Then ADD 0111+0001 → result=1000, V=1 C=0 N=1.
- W=4, SUB a=0011 b=0101 → result=1110, C=0 N=1 V=0. Then NAND 1100,1010 → 0111; NOR 1100,1010 → 0001, C=0.
- W=4, MUL 0011*0101 accepted at t → in_ready=0 for cycles t+1..t+3, out_valid=1 at t+4, result=1111, C=0. Then MUL 0110*0101 → result=1110, C=1.
- Backpressure: XOR 1010^0110 with out_ready=0 for 3 cycles → result=1100 held stable, in_ready=0; raise out_ready with in_valid=1 and AND 1111,0011 → back-to-back, next cycle result=0011 with out_valid continuously 1.
- Reset mid-MUL: assert rst 2 cycles after a MUL accept → next cycle state IDLE, out_valid=0. A subsequent ADD 0001+0001 → result=0010 with normal 1-cycle latency.
